// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program memory with streamed load port and multi-word registered fetch
//
// Purpose: holds a 2**A x W program image. A load session, started by
// LoadStart, streams words into consecutive addresses from 0. Once the load
// completes (LoadLast or memory full), fetches return N consecutive words per
// request, one cycle after the request.
//
// Ports:
//   Clk          single clock, rising edge
//   Reset_n      asynchronous active-low reset
//   LoadStart    pulse: begin (or restart) a load at address 0
//   LoadValid    LoadData carries a program word
//   LoadData     program word [W-1:0]
//   LoadLast     current word is the final word of the program
//   LoadReady    block accepts load words (high only while loading)
//   LoadDone     a load has completed since reset / LoadStart
//   LoadErr      last load filled memory without seeing LoadLast
//   LoadCount    words written by the current or last load [A:0]
//   FetchReq     fetch request, qualified by InstAddress
//   InstAddress  base address of the fetch [A-1:0]
//   InstOut      N fetched words; slice k = mem[(InstAddress+k) mod 2**A]
//   InstValid    one-cycle pulse: InstOut holds fresh fetch data

module prog_mem #(
    parameter int A = 10,
    parameter int W = 9,
    parameter int N = 2
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           LoadStart,
    input  logic           LoadValid,
    input  logic [W-1:0]   LoadData,
    input  logic           LoadLast,
    output logic           LoadReady,
    output logic           LoadDone,
    output logic           LoadErr,
    output logic [A:0]     LoadCount,
    input  logic           FetchReq,
    input  logic [A-1:0]   InstAddress,
    output logic [N*W-1:0] InstOut,
    output logic           InstValid
);

    localparam int DEPTH = 1 << A;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]     state;
    logic [W-1:0]   mem [DEPTH];
    logic [A-1:0]   ptr;
    logic           accept;
    logic           at_end;
    logic           fetch_go;
    logic [N*W-1:0] fetch_data;

    // The write pointer is the low bits of LoadCount: both clear together
    // and advance together, and the pointer never wraps because the load
    // terminates on the last address.
    assign ptr    = LoadCount[A-1:0];
    assign at_end = &ptr;

    assign LoadReady = (state == LOAD);

    // A LoadStart on the same edge restarts the load and discards the word.
    assign accept   = (state == LOAD) && LoadValid && !LoadStart;

    // LoadStart takes priority over a fetch issued on the same edge.
    assign fetch_go = (state == RUN) && FetchReq && !LoadStart;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            LoadCount <= '0;
            LoadDone  <= 1'b0;
            LoadErr   <= 1'b0;
        end else if (LoadStart) begin
            state     <= LOAD;
            LoadCount <= '0;
            LoadDone  <= 1'b0;
            LoadErr   <= 1'b0;
        end else if (accept) begin
            LoadCount <= LoadCount + {{A{1'b0}}, 1'b1};
            if (LoadLast) begin
                state    <= RUN;
                LoadDone <= 1'b1;
            end else if (at_end) begin
                // Memory full with no end-of-program marker.
                state    <= RUN;
                LoadDone <= 1'b1;
                LoadErr  <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset so a program survives reset.
    always_ff @(posedge Clk) begin
        if (accept && Reset_n) begin
            mem[ptr] <= LoadData;
        end
    end

    // Each fetch slice reads its own address; the A-bit sum wraps naturally.
    for (genvar k = 0; k < N; k++) begin : g_fetch
        logic [A-1:0] addr;
        assign addr = InstAddress + A'(k);
        assign fetch_data[k*W +: W] = mem[addr];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            InstOut   <= '0;
            InstValid <= 1'b0;
        end else begin
            InstValid <= fetch_go;
            if (fetch_go) begin
                InstOut <= fetch_data;
            end
        end
    end

endmodule
